// File: rtl/mesm6_ifetch.sv
// mesm6_ifetch
// Instruction-fetch unit for the MESM-6 core. Holds LINES 48-bit instruction
// words in a fully associative cache. When PREFETCH is set, it fetches the word
// after the last demand word while the bus is otherwise idle.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req         sequencer wants the opcode at pc
//   pc          half-word PC; bit 0 selects left [47:24] / right [23:0] opcode
//   flush       invalidate every line
//   ready       combinational hit for the current pc
//   opcode      selected 24-bit opcode, 0 when not ready
//   ibus_fetch  instruction bus request, held until ibus_done
//   ibus_addr   word address of the bus request
//   ibus_input  48-bit word returned by the bus
//   ibus_done   one-cycle completion strobe
module mesm6_ifetch #(
  parameter int ADDR_W   = 15,
  parameter int LINES    = 4,
  parameter int PREFETCH = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [ADDR_W:0]   pc,
  input  logic              flush,
  output logic              ready,
  output logic [23:0]       opcode,
  output logic              ibus_fetch,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic [47:0]       ibus_input,
  input  logic              ibus_done
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PREF = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [IDX_W-1:0]  rp_q, rp_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] tag_q [LINES];
  logic [47:0]       data_q [LINES];
  logic [ADDR_W-1:0] w_q;
  logic              w_vld_q;
  logic              fsup_q;

  logic [ADDR_W-1:0] pc_word_s;
  logic [ADDR_W-1:0] nxt_word_s;
  logic              hit_s;
  logic [47:0]       hit_data_s;
  logic              nxt_cached_s;
  logic              fa_cached_s;
  logic [IDX_W-1:0]  victim_s;
  logic              free_s;
  logic              we_s;

  assign pc_word_s  = pc[ADDR_W:1];
  // Wraps naturally at 2^ADDR_W.
  assign nxt_word_s = w_q + ADDR_W'(1);

  // Tag compare for the demand pc, the prefetch candidate and the in-flight
  // fill address. Tags are unique, so OR-ing the masked data is a clean mux.
  always_comb begin
    hit_s        = 1'b0;
    hit_data_s   = 48'd0;
    nxt_cached_s = 1'b0;
    fa_cached_s  = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      hit_s        = hit_s | (valid_q[i] & (tag_q[i] == pc_word_s));
      hit_data_s   = hit_data_s | (data_q[i] & {48{valid_q[i] & (tag_q[i] == pc_word_s)}});
      nxt_cached_s = nxt_cached_s | (valid_q[i] & (tag_q[i] == nxt_word_s));
      fa_cached_s  = fa_cached_s | (valid_q[i] & (tag_q[i] == fa_q));
    end
  end

  // Victim choice: lowest-index free line, otherwise the round-robin pointer.
  always_comb begin
    victim_s = rp_q;
    free_s   = 1'b0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim_s = IDX_W'(i);
        free_s   = 1'b1;
      end else begin
        free_s = free_s;
      end
    end
  end

  assign ready      = req & hit_s;
  assign opcode     = ready ? (pc[0] ? hit_data_s[23:0] : hit_data_s[47:24]) : 24'd0;
  assign ibus_fetch = (state_q != S_IDLE);
  assign ibus_addr  = ibus_fetch ? fa_q : {ADDR_W{1'b0}};

  // Next-state logic: miss handling, prefetch launch, fill completion, flush.
  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    rp_d    = rp_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    we_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && !hit_s) begin
          state_d = S_FILL;
          fa_d    = pc_word_s;
        end else if ((PREFETCH != 0) && w_vld_q && !fsup_q && !flush && !nxt_cached_s) begin
          state_d = S_PREF;
          fa_d    = nxt_word_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL, S_PREF: begin
        if (ibus_done) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          // A flushed transfer, or a word that is already present, is discarded.
          if (!flush && !drop_q && !fa_cached_s) begin
            we_s              = 1'b1;
            valid_d[victim_s] = 1'b1;
            if (!free_s) begin
              rp_d = (rp_q == LAST_IDX) ? {IDX_W{1'b0}} : rp_q + IDX_W'(1);
            end else begin
              rp_d = rp_q;
            end
          end else begin
            we_s = 1'b0;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      valid_d = {LINES{1'b0}};
      rp_d    = {IDX_W{1'b0}};
    end else begin
      valid_d = valid_d;
    end
  end

  // Control state: FSM, fill address, replacement pointer, valid bits, drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      fa_q    <= {ADDR_W{1'b0}};
      rp_q    <= {IDX_W{1'b0}};
      valid_q <= {LINES{1'b0}};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      rp_q    <= rp_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Line storage: only the victim line is written on a completed fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= {ADDR_W{1'b0}};
        data_q[i] <= 48'd0;
      end
    end else if (we_s) begin
      tag_q[victim_s]  <= fa_q;
      data_q[victim_s] <= ibus_input;
    end else begin
      tag_q[victim_s] <= tag_q[victim_s];
    end
  end

  // Last demand word (prefetch base) and one-cycle prefetch suppression after flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q     <= {ADDR_W{1'b0}};
      w_vld_q <= 1'b0;
      fsup_q  <= 1'b0;
    end else begin
      if (req) begin
        w_q     <= pc_word_s;
        w_vld_q <= 1'b1;
      end else begin
        w_q     <= w_q;
        w_vld_q <= w_vld_q;
      end
      fsup_q <= flush;
    end
  end

endmodule

// File: tb/tb_mesm6_ifetch.sv
module tb_mesm6_ifetch;

  logic        clk = 1'b0;
  logic        reset_n;
  // default instance: ADDR_W=15, LINES=4, PREFETCH=1
  logic        req, flush, ready, fetch, done;
  logic [15:0] pc;
  logic [23:0] opcode;
  logic [14:0] addr;
  logic [47:0] din;
  // second instance: LINES=2, PREFETCH=0
  logic        b_req, b_flush, b_ready, b_fetch, b_done;
  logic [15:0] b_pc;
  logic [23:0] b_opcode;
  logic [14:0] b_addr;
  logic [47:0] b_din;

  int total = 0;
  int bad   = 0;
  logic rsp_a, rsp_b;
  int   cnt_a, cnt_b, lat_a, lat_b;

  // reference model of the LINES=2 cache: resident words plus round-robin pointer
  localparam int BL = 2;
  logic [14:0] m_tag [BL];
  logic        m_val [BL];
  int          m_rp;

  always #5 clk = ~clk;

  mesm6_ifetch dut (
    .clk(clk), .reset_n(reset_n), .req(req), .pc(pc), .flush(flush),
    .ready(ready), .opcode(opcode), .ibus_fetch(fetch), .ibus_addr(addr),
    .ibus_input(din), .ibus_done(done)
  );

  mesm6_ifetch #(.ADDR_W(15), .LINES(2), .PREFETCH(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(b_req), .pc(b_pc), .flush(b_flush),
    .ready(b_ready), .opcode(b_opcode), .ibus_fetch(b_fetch), .ibus_addr(b_addr),
    .ibus_input(b_din), .ibus_done(b_done)
  );

  // instruction memory contents
  function automatic logic [47:0] memw(input logic [14:0] w);
    if (w == 15'd8) return 48'hAAAAAA_555555;
    return {9'h1A5, w, 9'h0C3, w};
  endfunction

  function automatic logic [23:0] half(input logic [15:0] p);
    logic [47:0] m;
    m = memw(p[15:1]);
    return p[0] ? m[23:0] : m[47:24];
  endfunction

  function automatic logic m_has(input logic [14:0] w);
    for (int i = 0; i < BL; i++) if (m_val[i] && m_tag[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_insert(input logic [14:0] w);
    for (int i = 0; i < BL; i++) begin
      if (!m_val[i]) begin
        m_val[i] = 1'b1;
        m_tag[i] = w;
        return;
      end
    end
    m_tag[m_rp] = w;
    m_rp = (m_rp + 1) % BL;
  endtask

  task automatic m_clear();
    for (int i = 0; i < BL; i++) m_val[i] = 1'b0;
    m_rp = 0;
  endtask

  // one clock; automatic bus responders answer just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (done) begin
      done = 1'b0; cnt_a = 0; lat_a = int'($urandom_range(0, 3));
    end else if (fetch && rsp_a) begin
      if (cnt_a >= lat_a) begin done = 1'b1; din = memw(addr); end
      else cnt_a++;
    end else cnt_a = 0;
    if (b_done) begin
      b_done = 1'b0; cnt_b = 0; lat_b = int'($urandom_range(0, 3));
    end else if (b_fetch && rsp_b) begin
      if (cnt_b >= lat_b) begin b_done = 1'b1; b_din = memw(b_addr); end
      else cnt_b++;
    end else cnt_b = 0;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = 1'b0; flush = 1'b0; done = 1'b0; pc = 16'h0000; din = 48'd0;
    b_req = 1'b0; b_flush = 1'b0; b_done = 1'b0; b_pc = 16'h0000; b_din = 48'd0;
    rsp_a = 1'b0; rsp_b = 1'b0; cnt_a = 0; cnt_b = 0; lat_a = 1; lat_b = 1;
    m_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 1'b1; pc = 16'h0010; flush = 1'b0; done = 1'b0; din = 48'd0;
    b_req = 1'b0; b_flush = 1'b0; b_done = 1'b0; b_pc = 16'h0000; b_din = 48'd0;
    #2;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    total++; if (opcode !== 24'd0) begin bad++; $display("FAIL reset_opcode: got %h want 000000", opcode); end
    total++; if (fetch !== 1'b0) begin bad++; $display("FAIL reset_fetch: got %b want 0", fetch); end
    total++; if (addr !== 15'd0) begin bad++; $display("FAIL reset_addr: got %h want 0000", addr); end
    do_reset();
    tick();
    total++; if (fetch !== 1'b0) begin bad++; $display("FAIL reset_no_prefetch: got %b want 0", fetch); end
  endtask

  task automatic test_cold_miss();
    do_reset();
    req = 1'b1; pc = 16'h0010; #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL cold_ready0: got %b want 0", ready); end
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'h0008) begin bad++; $display("FAIL cold_fetch: got %b/%h want 1/0008", fetch, addr); end
    tick(); tick();
    total++; if (fetch !== 1'b1 || addr !== 15'h0008 || ready !== 1'b0) begin bad++; $display("FAIL cold_hold: got %b/%h/%b want 1/0008/0", fetch, addr, ready); end
    din = 48'hAAAAAA_555555; done = 1'b1;
    tick();
    total++; if (ready !== 1'b1 || opcode !== 24'hAAAAAA) begin bad++; $display("FAIL cold_data: got %b/%h want 1/aaaaaa", ready, opcode); end
  endtask

  task automatic test_halfword_prefetch();
    pc = 16'h0011; #1;
    total++; if (ready !== 1'b1 || opcode !== 24'h555555) begin bad++; $display("FAIL half_hit: got %b/%h want 1/555555", ready, opcode); end
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'h0009) begin bad++; $display("FAIL pref_issue: got %b/%h want 1/0009", fetch, addr); end
    din = memw(15'd9); done = 1'b1;
    tick();
    total++; if (fetch !== 1'b0) begin bad++; $display("FAIL pref_done_idle: got %b want 0", fetch); end
    tick();
    total++; if (fetch !== 1'b0) begin bad++; $display("FAIL pref_no_repeat: got %b want 0", fetch); end
    pc = 16'h0012; #1;
    total++; if (ready !== 1'b1 || opcode !== half(16'h0012)) begin bad++; $display("FAIL pref_data: got %b/%h want 1/%h", ready, opcode, half(16'h0012)); end
  endtask

  task automatic test_flush_mid_fill();
    do_reset();
    req = 1'b1; pc = 16'h000A; #1;
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'd5) begin bad++; $display("FAIL flush_fill_start: got %b/%h want 1/0005", fetch, addr); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (fetch !== 1'b1 || addr !== 15'd5) begin bad++; $display("FAIL flush_transfer_kept: got %b/%h want 1/0005", fetch, addr); end
    din = memw(15'd5); done = 1'b1;
    tick();
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_dropped: got %b want 0", ready); end
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'd5) begin bad++; $display("FAIL flush_refetch: got %b/%h want 1/0005", fetch, addr); end
    din = memw(15'd5); done = 1'b1;
    tick();
    total++; if (ready !== 1'b1 || opcode !== half(16'h000A)) begin bad++; $display("FAIL flush_refill: got %b/%h want 1/%h", ready, opcode, half(16'h000A)); end
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'd6) begin bad++; $display("FAIL flush_pref6: got %b/%h want 1/0006", fetch, addr); end
    // flush coincident with completion: nothing written
    flush = 1'b1; din = memw(15'd6); done = 1'b1;
    tick();
    flush = 1'b0;
    pc = 16'h000C; #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_vs_done: got %b want 0", ready); end
    pc = 16'h000A; #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_cleared: got %b want 0", ready); end
    req = 1'b0;
    tick();
    total++; if (fetch !== 1'b0) begin bad++; $display("FAIL flush_pref_suppressed: got %b want 0", fetch); end
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'd6) begin bad++; $display("FAIL flush_pref_resume: got %b/%h want 1/0006", fetch, addr); end
  endtask

  task automatic test_wrap_prefetch();
    do_reset();
    req = 1'b1; pc = 16'hFFFE; #1;
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'h7FFF) begin bad++; $display("FAIL wrap_fill: got %b/%h want 1/7fff", fetch, addr); end
    din = memw(15'h7FFF); done = 1'b1;
    tick();
    total++; if (ready !== 1'b1 || opcode !== half(16'hFFFE)) begin bad++; $display("FAIL wrap_hit: got %b/%h want 1/%h", ready, opcode, half(16'hFFFE)); end
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'h0000) begin bad++; $display("FAIL wrap_pref: got %b/%h want 1/0000", fetch, addr); end
    din = memw(15'h0000); done = 1'b1;
    tick();
    pc = 16'h0000; #1;
    total++; if (ready !== 1'b1 || opcode !== half(16'h0000)) begin bad++; $display("FAIL wrap_zero_lat: got %b/%h want 1/%h", ready, opcode, half(16'h0000)); end
  endtask

  task automatic test_miss_during_prefetch();
    do_reset();
    req = 1'b1; pc = 16'h0006; #1;
    tick();
    din = memw(15'd3); done = 1'b1;
    tick();
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'd4) begin bad++; $display("FAIL mdp_pref4: got %b/%h want 1/0004", fetch, addr); end
    pc = 16'h000E; #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mdp_miss7: got %b want 0", ready); end
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'd4) begin bad++; $display("FAIL mdp_not_aborted: got %b/%h want 1/0004", fetch, addr); end
    din = memw(15'd4); done = 1'b1;
    tick();
    total++; if (fetch !== 1'b0) begin bad++; $display("FAIL mdp_idle_gap: got %b want 0", fetch); end
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'd7) begin bad++; $display("FAIL mdp_fill7: got %b/%h want 1/0007", fetch, addr); end
    din = memw(15'd7); done = 1'b1;
    tick();
    total++; if (ready !== 1'b1 || opcode !== half(16'h000E)) begin bad++; $display("FAIL mdp_ready7: got %b/%h want 1/%h", ready, opcode, half(16'h000E)); end
    pc = 16'h0009; #1;
    total++; if (ready !== 1'b1 || opcode !== half(16'h0009)) begin bad++; $display("FAIL mdp_word4: got %b/%h want 1/%h", ready, opcode, half(16'h0009)); end
    pc = 16'h0028; #1;
    tick();
    total++; if (fetch !== 1'b1 || addr !== 15'd20) begin bad++; $display("FAIL mdp_fill20: got %b/%h want 1/0014", fetch, addr); end
    reset_n = 1'b0; #1;
    total++; if (fetch !== 1'b0) begin bad++; $display("FAIL mdp_async_reset: got %b want 0", fetch); end
    do_reset();
  endtask

  task automatic b_access(input logic [14:0] w, input logic hb, input string nm);
    logic exp_hit;
    logic [15:0] p;
    int n;
    exp_hit = m_has(w);
    p = {w, hb};
    b_req = 1'b1; b_pc = p; #1;
    total++; if (b_ready !== exp_hit) begin bad++; $display("FAIL %s_hit w=%0d: got %b want %b", nm, w, b_ready, exp_hit); end
    n = 0;
    while (b_ready !== 1'b1 && n < 50) begin tick(); n++; end
    total++; if (b_ready !== 1'b1 || b_opcode !== half(p)) begin bad++; $display("FAIL %s_data w=%0d: got %b/%h want 1/%h", nm, w, b_ready, b_opcode, half(p)); end
    if (!exp_hit) m_insert(w);
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_replacement();
    do_reset();
    rsp_b = 1'b1;
    b_access(15'd1, 1'b0, "repl");
    b_access(15'd2, 1'b1, "repl");
    b_access(15'd3, 1'b0, "repl");
    b_access(15'd2, 1'b0, "repl");
    b_access(15'd1, 1'b1, "repl");
    b_access(15'd3, 1'b1, "repl");
    b_access(15'd2, 1'b0, "repl");
  endtask

  task automatic test_random_b();
    do_reset();
    rsp_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        m_clear();
      end
      b_access(15'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), "rand_b");
    end
  endtask

  task automatic test_random_a();
    int stall, worst, r;
    logic after_fl, p_fetch, p_done;
    logic [14:0] p_addr, w;
    do_reset();
    rsp_a = 1'b1;
    stall = 0; worst = 0; after_fl = 1'b0; p_fetch = 1'b0; p_done = 1'b0; p_addr = 15'd0;
    for (int c = 0; c < 500; c++) begin
      if (!req || ready) begin
        req = ($urandom_range(0, 3) != 0);
        r = int'($urandom_range(0, 13));
        w = (r < 12) ? 15'(r) : ((r == 12) ? 15'h7FFE : 15'h7FFF);
        pc = {w, 1'($urandom_range(0, 1))};
        stall = 0;
      end
      flush = ($urandom_range(0, 39) == 0);
      #1;
      if (after_fl) begin
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rand_after_flush: got %b want 0", ready); end
      end
      if (ready === 1'b1) begin
        total++; if (opcode !== half(pc)) begin bad++; $display("FAIL rand_opcode pc=%h: got %h want %h", pc, opcode, half(pc)); end
      end else if (req) begin
        stall++;
        if (stall > worst) worst = stall;
      end
      if (fetch && p_fetch && !p_done) begin
        total++; if (addr !== p_addr) begin bad++; $display("FAIL rand_addr_stable: got %h want %h", addr, p_addr); end
      end
      after_fl = flush; p_fetch = fetch; p_addr = addr; p_done = done;
      tick();
      flush = 1'b0;
    end
    total++; if (worst > 60) begin bad++; $display("FAIL rand_liveness: got %0d want <=60", worst); end
    rsp_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_halfword_prefetch();
    test_flush_mid_fill();
    test_wrap_prefetch();
    test_miss_during_prefetch();
    test_replacement();
    test_random_b();
    test_random_a();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
